// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined ripple-carry add/subtract. The WIDTH-bit operation is split
//   into STAGES chunks of CHUNK = WIDTH/STAGES bits. Stage k adds chunk k
//   using the carry registered by stage k-1. Upper operand chunks travel
//   forward in delay registers. Finished lower sum chunks travel with them,
//   so every chunk of one operation reaches the output together.
//   Latency is STAGES cycles and throughput is one operation per cycle.
//   A single global stall holds every stage while the output is blocked.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (a, b, carry_in, sub sampled on accept)
//   a, b            WIDTH-bit operands
//   carry_in        carry in (add) / borrow in (sub)
//   sub             0 = a + b + carry_in, 1 = a - b - carry_in
//   out_valid/ready result handshake
//   sum             WIDTH-bit result (modulo 2^WIDTH)
//   carry_out       final adder carry (sub: 1 = no borrow)
//   overflow        two's-complement signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Entry k of each array holds the state registered at the end of stage k.
  logic [STAGES-1:0]            v_q,   v_d;
  logic [STAGES-1:0]            c_q,   c_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q,   s_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q,   a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q,   b_d;
  logic                         ovf_q, ovf_d;

  logic advance;

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;

  // Every stage moves together. Nothing moves while a result is waiting
  // for downstream.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  always_comb begin
    logic             cur_v;
    logic             cur_c;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] cur_s;
    logic [CHUNK:0]   part;
    int unsigned      kp;

    v_d   = '0;
    c_d   = '0;
    s_d   = '0;
    a_d   = '0;
    b_d   = '0;
    ovf_d = 1'b0;
    cur_v = 1'b0;
    cur_c = 1'b0;
    cur_a = '0;
    cur_b = '0;
    cur_s = '0;
    part  = '0;
    kp    = 0;

    for (int unsigned k = 0; k < STAGES; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtract is a + ~b + ~borrow. b is inverted once here, and the
        // inverted value is the one carried through the delay registers.
        cur_v = in_valid;
        cur_c = carry_in ^ sub;
        cur_a = a;
        cur_b = sub ? ~b : b;
        cur_s = '0;
      end else begin
        cur_v = v_q[kp];
        cur_c = c_q[kp];
        cur_a = a_q[kp];
        cur_b = b_q[kp];
        cur_s = s_q[kp];
      end

      part = {1'b0, cur_a[k*CHUNK +: CHUNK]}
           + {1'b0, cur_b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, cur_c};

      v_d[k] = cur_v;
      c_d[k] = part[CHUNK];
      a_d[k] = cur_a;
      b_d[k] = cur_b;
      s_d[k] = cur_s;
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];

      // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
      if (k == STAGES - 1) begin
        ovf_d = cur_a[WIDTH-1] ^ cur_b[WIDTH-1] ^ part[CHUNK-1] ^ part[CHUNK];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      s_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      s_q   <= s_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits the WIDTH-bit add/subtract into STAGES equal chunks, with registered carry between chunks and skewed operand/result alignment.
- Supports one operation per cycle with valid/ready flow control on both sides.
- Provides per-operation add/subtract mode, carry-out and signed-overflow flags.
- Used wherever wide adds must close timing in datapath pipelines.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits added per stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry in (add) / borrow in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- carry_out  output  1  final carry (sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous, active-high; all stage valid bits, sum, carry_out, overflow and out_valid clear to 0 immediately. in_ready = 1 while rst is low and the pipeline is empty.
- Arithmetic:
  - sub=0: {carry_out,sum} = a + b + carry_in.
  - sub=1: sum = a + ~b + ~carry_in, i.e. a - b - carry_in; carry_out is the raw adder carry (1 = no borrow).
  - overflow = carry into MSB XOR carry out of MSB, for either mode.
  - Results are modulo 2^WIDTH; the wrap-around is reported only through carry_out and overflow.
- Pipeline:
  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 uses the effective carry in.
  - Upper operand chunks (with b already conditionally inverted) travel in delay registers.
  - Completed lower result chunks are delayed so all chunks of one operation emerge together.
  - STAGES=1 degenerates to a single registered adder.
- Latency: exactly STAGES clk edges from the accepting edge to out_valid=1, with no stall. Throughput is 1 operation/cycle.
- Handshake:
  - A beat is accepted on an edge where in_valid & in_ready.
  - Result is transferred on an edge where out_valid & out_ready.
  - Global stall: advance = !out_valid | out_ready. All stage registers advance together when advance=1 and hold when advance=0. in_ready = advance.
  - Bubbles (in_valid=0 while advancing) propagate as invalid stages. Bubbles are not collapsed.
- Output stability: while out_valid=1 and out_ready=0, sum, carry_out and overflow hold stable. a, b, sub and carry_in are sampled only at acceptance.
- Simultaneous events: accepting a new input and draining the output on the same edge is legal at full rate.
- Out-of-contract input: in_valid with in_ready=0 is ignored; the source must hold.
- Reset mid-operation: all in-flight operations are discarded with no partial output. The first valid result after release comes only from beats accepted after release.
- Elaboration: a WIDTH not divisible by STAGES is an elaboration error.

Test Plan:
- Carry ripple, WIDTH=32 STAGES=4: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, carry_out=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, carry_out=0, overflow=1. Subtract a=5, b=7, cin=0 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
- Streaming: 100 random back-to-back beats with out_ready=1 -> in_ready stays 1; results appear in order, one per cycle, matching the reference model; first result at cycle 4.
- Backpressure: stream with out_ready=0 for cycles 6-9 -> in_ready=0 and out_valid=1 held, with sum/carry_out/overflow unchanged across those cycles; no beat lost or duplicated after release.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid=0 immediately and no stale result ever appears; a subsequent beat 3+4 yields sum=7 after 4 cycles.
- Configs: repeat the carry-ripple and streaming tests with WIDTH=8 STAGES=1 (latency 1; 0xFF+0x01 -> 0x00, carry_out=1) and WIDTH=8 STAGES=8.
